// File: rtl/reg_bank_reader.sv
// reg_bank_reader: snapshots a bank of register outputs on request and
// streams a contiguous range of the snapshot over a valid/ready handshake.
// Optional build macro READBACK_PARITY_EN adds out_parity (even parity of
// out_data, registered alongside it).
module reg_bank_reader #(
    parameter int SZ_DATA  = 32,
    parameter int NUM_REGS = 8,
    parameter int SZ_IDX   = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REGS*SZ_DATA-1:0] regs_flat,
    input  logic                        req,
    input  logic [SZ_IDX-1:0]           req_first,
    input  logic [SZ_IDX:0]             req_count,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SZ_DATA-1:0]          out_data,
    output logic [SZ_IDX-1:0]           out_idx,
    output logic                        out_last,
`ifdef READBACK_PARITY_EN
    output logic                        out_parity,
`endif
    output logic                        busy,
    output logic                        req_err,
    output logic                        req_drop
);

    typedef enum logic {IDLE, STREAM} state_t;

    typedef logic [NUM_REGS-1:0][SZ_DATA-1:0] bank_t;

    state_t             state_q, state_d;
    bank_t              shadow_q, shadow_d;
    bank_t              regs_w;
    logic [SZ_IDX:0]    rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic [SZ_DATA-1:0] out_data_q, out_data_d;
    logic [SZ_IDX-1:0]  out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;
    logic               req_err_q, req_err_d;
    logic               req_drop_q, req_drop_d;
    logic [SZ_IDX+1:0]  range_end;
    logic               range_bad;
    logic [SZ_IDX-1:0]  nxt_idx;

    assign regs_w    = regs_flat;
    // Range end computed two bits wider than the index so it cannot wrap.
    assign range_end = {2'b00, req_first} + {1'b0, req_count};
    assign range_bad = (req_count == '0) || (range_end > (SZ_IDX+2)'(NUM_REGS));
    assign nxt_idx   = out_idx_q + 1'b1;

    // Next-state and registered-output computation for the IDLE/STREAM FSM.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        req_err_d   = 1'b0;
        req_drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (range_bad) begin
                        req_err_d = 1'b1;
                    end else begin
                        // Snapshot and first word come from the same edge, so
                        // the first word is read straight from regs_flat.
                        shadow_d    = regs_w;
                        rem_d       = req_count;
                        out_idx_d   = req_first;
                        out_data_d  = regs_w[req_first];
                        out_last_d  = (req_count == (SZ_IDX+1)'(1));
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = STREAM;
                    end
                end
            end
            STREAM: begin
                req_drop_d = req;
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        rem_d       = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_idx_d   = '0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        rem_d      = rem_q - 1'b1;
                        out_idx_d  = nxt_idx;
                        out_data_d = shadow_q[nxt_idx];
                        out_last_d = (rem_q == (SZ_IDX+1)'(2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_err_q   <= 1'b0;
            req_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            req_err_q   <= req_err_d;
            req_drop_q  <= req_drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign req_err   = req_err_q;
    assign req_drop  = req_drop_q;

`ifdef READBACK_PARITY_EN
    logic out_parity_q;

    // Parity tracks the registered word, so it holds with it under backpressure.
    always_ff @(posedge clk) begin
        if (rst) out_parity_q <= 1'b0;
        else     out_parity_q <= ^out_data_d;
    end

    assign out_parity = out_parity_q;
`endif

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
Read-side companion to the team's register/enable storage cells. It takes an atomic snapshot of a bank of register outputs on request and streams a contiguous range of them out as words over a valid/ready handshake. It sits between the control-register bank and the readback/telemetry path, so software sees a coherent multi-word view of registers that other logic keeps writing.

Parameters:
SZ_DATA, 32, width of each register word and of out_data
NUM_REGS, 8, number of registers in the bank (>=2)
SZ_IDX, $clog2(NUM_REGS), width of register index fields

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
regs_flat  input  NUM_REGS*SZ_DATA  concatenated register outputs; register i at bits [i*SZ_DATA +: SZ_DATA]
req  input  1  read request, sampled each cycle
req_first  input  SZ_IDX  index of first register to stream
req_count  input  SZ_IDX+1  number of registers to stream
out_valid  output  1  out_data/out_idx/out_last valid
out_ready  input  1  downstream accepts the current word
out_data  output  SZ_DATA  snapshot word
out_idx  output  SZ_IDX  register index of out_data
out_last  output  1  final word of the burst
busy  output  1  burst in progress
req_err  output  1  one-cycle pulse: request rejected for bad range
req_drop  output  1  one-cycle pulse: request ignored because busy

Behaviour:
- Single clock clk. Synchronous active-high rst: state IDLE, all outputs 0, shadow bank cleared to 0, index and remaining counters 0.
- States: IDLE, STREAM.
- IDLE, req=0: hold; busy=0, out_valid=0.
- IDLE, req=1, req_count==0 or req_first+req_count>NUM_REGS (compare at SZ_IDX+2 bits, no wrap): req_err=1 for the next cycle only, stay IDLE, shadow unchanged.
- IDLE, req=1, valid range: at that clock edge, copy all NUM_REGS words of regs_flat into the shadow bank, idx<=req_first, remaining<=req_count, go to STREAM. busy=1 and out_valid=1 from the next cycle. Latency from req to first out_valid is 1 cycle.
- STREAM: out_data=shadow[idx], out_idx=idx, out_last=(remaining==1), all registered.
- Beat completes when out_valid&&out_ready. Non-last beat: idx+1, remaining-1, next word presented the next cycle. Back-to-back beats run at 1 word/cycle with out_ready held high.
- Last beat: next cycle state=IDLE, out_valid=0, busy=0, out_last=0.
- out_valid&&!out_ready: out_data, out_idx and out_last hold stable. out_valid does not drop until the beat is accepted.
- Changes on regs_flat after the snapshot edge do not affect the burst.
- req=1 while in STREAM, including the cycle of the final handshake: ignored, req_drop=1 next cycle. A new request is accepted only once busy=0.
- rst mid-burst: abort immediately. Next cycle state=IDLE with outputs per reset. No partial word is re-presented.
- req_err and req_drop are never asserted in the same cycle.

Optional Feature:
READBACK_PARITY_EN
- Defined: adds output port out_parity (1 bit) = XOR of out_data bits (even parity), registered with out_data, held stable under backpressure, 0 on reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then req with first=2, count=3, out_ready=1, regs i = 0x1000+i -> out_valid cycles 1..3 after req, data 0x1002/0x1003/0x1004, idx 2/3/4, out_last only on 0x1004, busy falls the cycle after.
- Same request, regs_flat rewritten to 0xDEAD_0000+i the cycle after req -> stream still 0x1002..0x1004, proving the snapshot.
- out_ready low for 4 cycles on the second beat -> out_data=0x1003, idx=3 held stable, out_valid high throughout, no beat skipped.
- req first=6, count=3 (NUM_REGS=8), and separately count=0 -> req_err one-cycle pulse each, busy stays 0, out_valid never rises.
- req pulsed during STREAM and again on the final-beat handshake cycle -> req_drop pulse each time, no second burst starts. A req one cycle after busy=0 is accepted.
- rst asserted during the 2nd of 4 beats -> next cycle out_valid=0, busy=0. A fresh req streams from its own req_first. With READBACK_PARITY_EN, out_parity matches XOR(out_data) on every beat.
